// File: rtl/int_pkg.sv
// Shared constants for the machine-mode interrupt controller: CSR addresses,
// mcause codes, CSR bit positions and the controller state encoding.
package int_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MIP     = 12'h344;

    localparam logic [31:0] MCAUSE_EXT     = 32'h8000_000B;
    localparam logic [31:0] MCAUSE_TIMER   = 32'h8000_0007;
    localparam logic [31:0] MCAUSE_ILLEGAL = 32'd2;
    localparam logic [31:0] MCAUSE_ECALL   = 32'd11;
    localparam logic [31:0] MCAUSE_EBREAK  = 32'd3;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;
    localparam int MIE_MEIE     = 11;
    localparam int MIE_MTIE     = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TRAP = 2'd1,
        ST_MRET = 2'd2
    } int_state_e;

endpackage

// File: rtl/int_csr_regs.sv
// Machine-mode CSR storage (mstatus, mie, mtvec, mepc, mcause) with the
// combinational read mux; trap/mret field updates take precedence over writes.
module int_csr_regs
    import int_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        csr_we_i,
    input  logic [11:0] csr_waddr_i,
    input  logic [31:0] csr_wdata_i,
    input  logic [11:0] csr_raddr_i,
    output logic [31:0] csr_rdata_o,
    input  logic        trap_i,
    input  logic [31:0] trap_epc_i,
    input  logic [31:0] trap_cause_i,
    input  logic        mret_i,
    input  logic        ext_irq_i,
    input  logic        timer_irq_i,
    output logic        mstatus_mie_o,
    output logic        mie_meie_o,
    output logic        mie_mtie_o,
    output logic [31:0] mtvec_o,
    output logic [31:0] mepc_o
);

    logic        mie_q,    mie_d;
    logic        mpie_q,   mpie_d;
    logic        meie_q,   meie_d;
    logic        mtie_q,   mtie_d;
    logic [31:0] mtvec_q,  mtvec_d;
    logic [31:0] mepc_q,   mepc_d;
    logic [31:0] mcause_q, mcause_d;

    always_comb begin
        mie_d    = mie_q;
        mpie_d   = mpie_q;
        meie_d   = meie_q;
        mtie_d   = mtie_q;
        mtvec_d  = mtvec_q;
        mepc_d   = mepc_q;
        mcause_d = mcause_q;

        if (csr_we_i) begin
            case (csr_waddr_i)
                CSR_MSTATUS: begin
                    mie_d  = csr_wdata_i[MSTATUS_MIE];
                    mpie_d = csr_wdata_i[MSTATUS_MPIE];
                end
                CSR_MIE: begin
                    meie_d = csr_wdata_i[MIE_MEIE];
                    mtie_d = csr_wdata_i[MIE_MTIE];
                end
                CSR_MTVEC:  mtvec_d  = {csr_wdata_i[31:2], 2'b00};
                CSR_MEPC:   mepc_d   = {csr_wdata_i[31:2], 2'b00};
                CSR_MCAUSE: mcause_d = csr_wdata_i;
                default: ;
            endcase
        end

        // Trap/mret are applied last so they override a same-cycle CSR write
        if (trap_i) begin
            mepc_d   = {trap_epc_i[31:2], 2'b00};
            mcause_d = trap_cause_i;
            mpie_d   = mie_q;
            mie_d    = 1'b0;
        end else if (mret_i) begin
            mie_d    = mpie_q;
            mpie_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mie_q    <= 1'b0;
            mpie_q   <= 1'b0;
            meie_q   <= 1'b0;
            mtie_q   <= 1'b0;
            mtvec_q  <= 32'd0;
            mepc_q   <= 32'd0;
            mcause_q <= 32'd0;
        end else begin
            mie_q    <= mie_d;
            mpie_q   <= mpie_d;
            meie_q   <= meie_d;
            mtie_q   <= mtie_d;
            mtvec_q  <= mtvec_d;
            mepc_q   <= mepc_d;
            mcause_q <= mcause_d;
        end
    end

    always_comb begin
        csr_rdata_o = 32'd0;
        case (csr_raddr_i)
            CSR_MSTATUS: begin
                csr_rdata_o[MSTATUS_MIE]  = mie_q;
                csr_rdata_o[MSTATUS_MPIE] = mpie_q;
            end
            CSR_MIE: begin
                csr_rdata_o[MIE_MEIE] = meie_q;
                csr_rdata_o[MIE_MTIE] = mtie_q;
            end
            CSR_MTVEC:  csr_rdata_o = mtvec_q;
            CSR_MEPC:   csr_rdata_o = mepc_q;
            CSR_MCAUSE: csr_rdata_o = mcause_q;
            CSR_MIP: begin
                csr_rdata_o[MIE_MEIE] = ext_irq_i;
                csr_rdata_o[MIE_MTIE] = timer_irq_i;
            end
            default: ;
        endcase
    end

    assign mstatus_mie_o = mie_q;
    assign mie_meie_o    = meie_q;
    assign mie_mtie_o    = mtie_q;
    assign mtvec_o       = mtvec_q;
    assign mepc_o        = mepc_q;

endmodule

// File: rtl/interrupt_ctrl.sv
// Machine-mode trap/interrupt controller: prioritises events at an accepted
// instruction boundary and issues a one-cycle PC redirect and flush.
module interrupt_ctrl
    import int_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ctrl_int_valid,
    input  logic        ctrl_int_ready,
    input  logic [31:0] ctrl_int_epc,
    input  logic        ctrl_int_ebreak,
    input  logic        ctrl_int_ecall,
    input  logic        ctrl_int_mret,
    input  logic        ctrl_int_illegal,
    input  logic        ext_irq,
    input  logic        timer_irq,
    input  logic        csr_we,
    input  logic [11:0] csr_waddr,
    input  logic [31:0] csr_wdata,
    input  logic [11:0] csr_raddr,
    output logic [31:0] csr_rdata,
    output logic [31:0] int_ctrl_mtvec,
    output logic [31:0] int_ctrl_epc,
    output logic        int_ctrl_pcen,
    output logic        int_ctrl_flush_req,
    output logic        excp_pcen,
    output logic        int_busy
);

    int_state_e  state_q;
    logic        pcen_q, flush_q, excp_q, busy_q;

    logic        mstatus_mie, mie_meie, mie_mtie;
    logic        accept, ext_evt, tmr_evt;
    logic        trap_take, mret_take;
    logic [31:0] trap_cause;

    assign accept  = (state_q == ST_IDLE) & ctrl_int_valid & ctrl_int_ready;
    assign ext_evt = ext_irq   & mie_meie & mstatus_mie;
    assign tmr_evt = timer_irq & mie_mtie & mstatus_mie;

    always_comb begin
        trap_cause = 32'd0;
        trap_take  = 1'b0;
        mret_take  = 1'b0;
        if (accept) begin
            trap_take = 1'b1;
            if (ext_evt)               trap_cause = MCAUSE_EXT;
            else if (tmr_evt)          trap_cause = MCAUSE_TIMER;
            else if (ctrl_int_illegal) trap_cause = MCAUSE_ILLEGAL;
            else if (ctrl_int_ecall)   trap_cause = MCAUSE_ECALL;
            else if (ctrl_int_ebreak)  trap_cause = MCAUSE_EBREAK;
            else begin
                trap_take = 1'b0;
                mret_take = ctrl_int_mret;
            end
        end
    end

    // Strobes are registered so they are glitch-free and clear on async reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pcen_q  <= 1'b0;
            flush_q <= 1'b0;
            excp_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (trap_take) begin
                        state_q <= ST_TRAP;
                        pcen_q  <= 1'b1;
                        flush_q <= 1'b1;
                        excp_q  <= ~trap_cause[31];
                        busy_q  <= 1'b1;
                    end else if (mret_take) begin
                        state_q <= ST_MRET;
                        pcen_q  <= 1'b1;
                        flush_q <= 1'b1;
                        excp_q  <= 1'b0;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                        pcen_q  <= 1'b0;
                        flush_q <= 1'b0;
                        excp_q  <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    pcen_q  <= 1'b0;
                    flush_q <= 1'b0;
                    excp_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    int_csr_regs u_csr (
        .clk           (clk),
        .rst_n         (rst_n),
        .csr_we_i      (csr_we),
        .csr_waddr_i   (csr_waddr),
        .csr_wdata_i   (csr_wdata),
        .csr_raddr_i   (csr_raddr),
        .csr_rdata_o   (csr_rdata),
        .trap_i        (trap_take),
        .trap_epc_i    (ctrl_int_epc),
        .trap_cause_i  (trap_cause),
        .mret_i        (mret_take),
        .ext_irq_i     (ext_irq),
        .timer_irq_i   (timer_irq),
        .mstatus_mie_o (mstatus_mie),
        .mie_meie_o    (mie_meie),
        .mie_mtie_o    (mie_mtie),
        .mtvec_o       (int_ctrl_mtvec),
        .mepc_o        (int_ctrl_epc)
    );

    assign int_ctrl_pcen      = pcen_q;
    assign int_ctrl_flush_req = flush_q;
    assign excp_pcen          = excp_q;
    assign int_busy           = busy_q;

endmodule

// File: tb/tb_interrupt_ctrl.sv
// Self-checking bench for interrupt_ctrl: directed scenarios with literal
// expectations, then randomized traffic checked against a behavioural model.
module tb_interrupt_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ctrl_int_valid = 1'b0, ctrl_int_ready = 1'b0;
    logic [31:0] ctrl_int_epc = 32'd0;
    logic        ctrl_int_ebreak = 1'b0, ctrl_int_ecall = 1'b0;
    logic        ctrl_int_mret = 1'b0, ctrl_int_illegal = 1'b0;
    logic        ext_irq = 1'b0, timer_irq = 1'b0;
    logic        csr_we = 1'b0;
    logic [11:0] csr_waddr = 12'd0;
    logic [31:0] csr_wdata = 32'd0;
    logic [11:0] csr_raddr = 12'd0;
    logic [31:0] csr_rdata;
    logic [31:0] int_ctrl_mtvec, int_ctrl_epc;
    logic        int_ctrl_pcen, int_ctrl_flush_req, excp_pcen, int_busy;

    int total = 0;
    int bad   = 0;

    interrupt_ctrl dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .ctrl_int_valid     (ctrl_int_valid),
        .ctrl_int_ready     (ctrl_int_ready),
        .ctrl_int_epc       (ctrl_int_epc),
        .ctrl_int_ebreak    (ctrl_int_ebreak),
        .ctrl_int_ecall     (ctrl_int_ecall),
        .ctrl_int_mret      (ctrl_int_mret),
        .ctrl_int_illegal   (ctrl_int_illegal),
        .ext_irq            (ext_irq),
        .timer_irq          (timer_irq),
        .csr_we             (csr_we),
        .csr_waddr          (csr_waddr),
        .csr_wdata          (csr_wdata),
        .csr_raddr          (csr_raddr),
        .csr_rdata          (csr_rdata),
        .int_ctrl_mtvec     (int_ctrl_mtvec),
        .int_ctrl_epc       (int_ctrl_epc),
        .int_ctrl_pcen      (int_ctrl_pcen),
        .int_ctrl_flush_req (int_ctrl_flush_req),
        .excp_pcen          (excp_pcen),
        .int_busy           (int_busy)
    );

    always #5 clk = ~clk;

    // Architectural view of the controller: CSR fields plus the kind of
    // redirect (0 none, 1 trap, 2 mret) owed in the cycle after an event.
    logic        m_mie = 0, m_mpie = 0, m_meie = 0, m_mtie = 0;
    logic [31:0] m_mtvec = 0, m_mepc = 0, m_mcause = 0;
    int          m_redir = 0;
    logic        m_excp = 0;
    int          ev;
    logic [31:0] ev_cause;
    logic        old_mie, old_mpie;

    function automatic logic [31:0] m_read(input logic [11:0] a);
        case (a)
            12'h300: return (32'(m_mpie) << 7) | (32'(m_mie) << 3);
            12'h304: return (32'(m_meie) << 11) | (32'(m_mtie) << 7);
            12'h305: return m_mtvec;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h344: return (32'(ext_irq) << 11) | (32'(timer_irq) << 7);
            default: return 32'd0;
        endcase
    endfunction

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_mie = 0; m_mpie = 0; m_meie = 0; m_mtie = 0;
            m_mtvec = 0; m_mepc = 0; m_mcause = 0;
            m_redir = 0; m_excp = 0;
        end else begin
            ev = 0;
            ev_cause = 0;
            old_mie = m_mie;
            old_mpie = m_mpie;
            if (m_redir == 0 && ctrl_int_valid && ctrl_int_ready) begin
                if (ext_irq && m_meie && m_mie)        begin ev = 1; ev_cause = 32'h8000000B; end
                else if (timer_irq && m_mtie && m_mie) begin ev = 1; ev_cause = 32'h80000007; end
                else if (ctrl_int_illegal)             begin ev = 1; ev_cause = 2; end
                else if (ctrl_int_ecall)               begin ev = 1; ev_cause = 11; end
                else if (ctrl_int_ebreak)              begin ev = 1; ev_cause = 3; end
                else if (ctrl_int_mret)                ev = 2;
            end
            if (csr_we) begin
                case (csr_waddr)
                    12'h300: begin m_mie = csr_wdata[3]; m_mpie = csr_wdata[7]; end
                    12'h304: begin m_meie = csr_wdata[11]; m_mtie = csr_wdata[7]; end
                    12'h305: m_mtvec = csr_wdata & 32'hFFFF_FFFC;
                    12'h341: m_mepc = csr_wdata & 32'hFFFF_FFFC;
                    12'h342: m_mcause = csr_wdata;
                    default: ;
                endcase
            end
            if (ev == 1) begin
                m_mepc = ctrl_int_epc & 32'hFFFF_FFFC;
                m_mcause = ev_cause;
                m_mpie = old_mie;
                m_mie = 0;
            end else if (ev == 2) begin
                m_mie = old_mpie;
                m_mpie = 1;
            end
            m_redir = ev;
            m_excp = (ev == 1) && !ev_cause[31];
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the rising edge
    initial forever begin
        @(negedge clk);
        chk("pcen",      32'(int_ctrl_pcen),      32'(m_redir != 0));
        chk("flush",     32'(int_ctrl_flush_req), 32'(m_redir != 0));
        chk("excp_pcen", 32'(excp_pcen),          32'(m_excp));
        chk("busy",      32'(int_busy),           32'(m_redir != 0));
        chk("mtvec_out", int_ctrl_mtvec,          m_mtvec);
        chk("epc_out",   int_ctrl_epc,            m_mepc);
        chk("rdata",     csr_rdata,               m_read(csr_raddr));
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ctrl_int_valid = 0; ctrl_int_ready = 0;
        ctrl_int_ebreak = 0; ctrl_int_ecall = 0;
        ctrl_int_mret = 0; ctrl_int_illegal = 0;
        csr_we = 0;
    endtask

    task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
        csr_we = 1; csr_waddr = a; csr_wdata = d;
        tick();
        csr_we = 0;
    endtask

    task automatic rd(input string name, input logic [11:0] a, input logic [31:0] exp);
        csr_raddr = a;
        #1;
        chk(name, csr_rdata, exp);
    endtask

    logic [11:0] addrs [8];
    int          pulses;

    initial begin
        addrs = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h344, 12'h301, 12'h7C0};

        repeat (3) @(negedge clk);
        #1;
        chk("rst_pcen", 32'(int_ctrl_pcen), 0);
        chk("rst_busy", 32'(int_busy), 0);
        rd("rst_mstatus", 12'h300, 0);
        rst_n = 1;
        tick();

        // mtvec low bits are hard-wired to zero
        csr_write(12'h305, 32'h0000_0103);
        rd("mtvec_rd", 12'h305, 32'h0000_0100);
        chk("mtvec_port", int_ctrl_mtvec, 32'h0000_0100);

        // ecall at 0x80, held through the TRAP cycle with a new epc
        ctrl_int_valid = 1; ctrl_int_ready = 1; ctrl_int_ecall = 1; ctrl_int_epc = 32'h80;
        tick();
        chk("ecall_pcen",  32'(int_ctrl_pcen), 1);
        chk("ecall_flush", 32'(int_ctrl_flush_req), 1);
        chk("ecall_excp",  32'(excp_pcen), 1);
        rd("ecall_mepc",   12'h341, 32'h80);
        rd("ecall_mcause", 12'h342, 32'd11);
        ctrl_int_epc = 32'h84;
        tick();
        idle_inputs();
        chk("ecall_single_pulse", 32'(int_ctrl_pcen), 0);
        rd("ecall_mcause_kept", 12'h342, 32'd11);
        rd("ecall_mepc_kept",   12'h341, 32'h80);
        tick();

        // external interrupt outranks an illegal instruction
        csr_write(12'h300, 32'h8);
        csr_write(12'h304, 32'h800);
        ext_irq = 1; ctrl_int_illegal = 1; ctrl_int_valid = 1; ctrl_int_ready = 1;
        ctrl_int_epc = 32'h40;
        tick();
        idle_inputs();
        ext_irq = 0;
        chk("ext_pcen", 32'(int_ctrl_pcen), 1);
        chk("ext_excp", 32'(excp_pcen), 0);
        rd("ext_mcause",  12'h342, 32'h8000_000B);
        rd("ext_mstatus", 12'h300, 32'h80);
        tick();

        // mret returns to 0x40 and restores MIE
        ctrl_int_mret = 1; ctrl_int_valid = 1; ctrl_int_ready = 1;
        tick();
        idle_inputs();
        chk("mret_pcen", 32'(int_ctrl_pcen), 1);
        chk("mret_epc",  int_ctrl_epc, 32'h40);
        rd("mret_mstatus", 12'h300, 32'h88);
        tick();

        // timer pending with MIE clear must not trap
        csr_write(12'h300, 32'h0);
        csr_write(12'h304, 32'h80);
        timer_irq = 1; ctrl_int_valid = 1; ctrl_int_ready = 1;
        pulses = 0;
        repeat (5) begin
            tick();
            if (int_ctrl_pcen) pulses++;
        end
        chk("mie0_no_pcen", 32'(pulses), 0);
        rd("mip_timer", 12'h344, 32'h80);
        idle_inputs();
        timer_irq = 0;
        tick();

        // asynchronous reset in the middle of TRAP
        ctrl_int_valid = 1; ctrl_int_ready = 1; ctrl_int_ebreak = 1; ctrl_int_epc = 32'h200;
        tick();
        idle_inputs();
        chk("pre_rst_pcen", 32'(int_ctrl_pcen), 1);
        #1 rst_n = 0;
        #1;
        chk("arst_pcen",  32'(int_ctrl_pcen), 0);
        chk("arst_flush", 32'(int_ctrl_flush_req), 0);
        chk("arst_excp",  32'(excp_pcen), 0);
        chk("arst_busy",  32'(int_busy), 0);
        chk("arst_epc",   int_ctrl_epc, 0);
        for (int k = 0; k < 5; k++) rd("arst_csr", addrs[k], 0);
        @(negedge clk);
        rst_n = 1;
        tick();

        for (int i = 0; i < 3000; i++) begin
            ctrl_int_valid   = ($urandom_range(0, 3) != 0);
            ctrl_int_ready   = ($urandom_range(0, 3) != 0);
            ctrl_int_epc     = $urandom;
            ctrl_int_illegal = ($urandom_range(0, 9) == 0);
            ctrl_int_ecall   = ($urandom_range(0, 9) == 0);
            ctrl_int_ebreak  = ($urandom_range(0, 9) == 0);
            ctrl_int_mret    = ($urandom_range(0, 5) == 0);
            ext_irq          = ($urandom_range(0, 3) == 0);
            timer_irq        = ($urandom_range(0, 3) == 0);
            csr_we           = ($urandom_range(0, 4) == 0);
            csr_waddr        = addrs[$urandom_range(0, 7)];
            csr_wdata        = $urandom;
            csr_raddr        = addrs[$urandom_range(0, 7)];
            if (i % 1000 == 999) begin
                rst_n = 0;
                tick();
                rst_n = 1;
            end
            tick();
        end
        idle_inputs();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/interrupt_ctrl.md
INTERRUPT_CTRL -- requirements
Module: interrupt_ctrl

Interface
REQ-001 SHALL use one clock and an asynchronous, active-low reset: clk input 1, rising-edge clock; rst_n input 1, asynchronous active-low reset.
REQ-002 ctrl_int_valid / ctrl_int_ready: input 1 each; the instruction at the boundary is accepted when both are 1.
REQ-003 ctrl_int_epc: input 32; PC of the accepted instruction.
REQ-004 ctrl_int_ebreak / ctrl_int_ecall / ctrl_int_mret / ctrl_int_illegal: input 1 each; decode flags of the accepted instruction.
REQ-005 ext_irq / timer_irq: input 1 each; level interrupt requests, already synchronous to clk.
REQ-006 csr_we input 1, csr_waddr input 12, csr_wdata input 32: CSR write port.
REQ-007 csr_raddr input 12, csr_rdata output 32: combinational CSR read port.
REQ-008 int_ctrl_mtvec output 32: trap target PC.
REQ-009 int_ctrl_epc output 32: mret return PC (current mepc).
REQ-010 int_ctrl_pcen output 1: PC-redirect strobe.
REQ-011 int_ctrl_flush_req output 1: pipeline flush strobe.
REQ-012 excp_pcen output 1: synchronous-exception redirect strobe (overrides BIU stall).
REQ-013 int_busy output 1: high whenever the FSM is not in IDLE.

Function
REQ-014 CSRs SHALL be: mstatus 0x300 (MIE bit3, MPIE bit7, other bits read 0), mie 0x304 (MEIE bit11, MTIE bit7), mtvec 0x305 (bits[1:0] read 0, direct mode only), mepc 0x341 (bits[1:0] read 0), mcause 0x342, mip 0x344 (read-only: MEIP = ext_irq, MTIP = timer_irq).
REQ-015 Reads of unimplemented addresses SHALL return 0; writes to them and to mip SHALL be ignored.
REQ-016 The FSM SHALL have three states: IDLE, TRAP and MRET.
REQ-017 An event SHALL be evaluated only in IDLE, in a cycle where ctrl_int_valid & ctrl_int_ready = 1.
REQ-018 Event priority SHALL be: external interrupt (ext_irq & MEIE & MIE) > timer interrupt (timer_irq & MTIE & MIE) > illegal > ecall > ebreak > mret.
REQ-019 mcause values SHALL be: external 0x8000000B, timer 0x80000007, illegal 2, ecall 11, ebreak 3.
REQ-020 On a trap event in cycle N, at the edge ending N the block SHALL write mepc = ctrl_int_epc, write mcause, set MPIE = MIE, clear MIE, and enter TRAP.
REQ-021 In TRAP (cycle N+1) the block SHALL assert int_ctrl_pcen = 1 and int_ctrl_flush_req = 1 for exactly one cycle.
REQ-022 In TRAP, excp_pcen SHALL be 1 only for synchronous causes (mcause bit31 = 0).
REQ-023 After TRAP the FSM SHALL return to IDLE.
REQ-024 On an mret event in cycle N, the block SHALL set MIE = MPIE and MPIE = 1, and enter MRET.
REQ-025 In MRET (cycle N+1) the block SHALL assert int_ctrl_pcen = 1 and int_ctrl_flush_req = 1 for one cycle, with int_ctrl_epc = mepc, then return to IDLE.
REQ-026 int_ctrl_mtvec and int_ctrl_epc SHALL be continuous copies of mtvec and mepc.
REQ-027 Events occurring in TRAP or MRET SHALL be ignored; the flushed instruction is refetched.
REQ-028 If a CSR write and a trap or mret update target the same register in one cycle, the trap or mret update SHALL win; other fields still take the CSR write.
REQ-029 Interrupt requests SHALL NOT be latched: an interrupt is taken only if pending at an accepted boundary.
REQ-030 The worst-case redirect latency SHALL be 1 cycle from the accepted boundary.

Reset
REQ-031 On rst_n = 0 the FSM SHALL go to IDLE, all CSRs SHALL be 0, and int_ctrl_pcen, int_ctrl_flush_req, excp_pcen and int_busy SHALL be 0, immediately (asynchronously).
REQ-032 If reset is asserted while in TRAP or MRET, the pending strobe SHALL be dropped; no partial CSR update SHALL persist beyond reset.

Structure
REQ-033 The shared package int_pkg SHALL hold the CSR address constants, the mcause codes and the FSM state enum.
REQ-034 The CSR storage and read mux SHALL be one sub-module, int_csr_regs; the FSM and priority logic stay in interrupt_ctrl.
REQ-035 The implementation SHALL be about 200-300 lines of RTL in total.

Verification
REQ-036 Write mtvec = 0x00000103, read it back -> 0x00000100. Then ecall at epc 0x80: next cycle pcen = flush = excp_pcen = 1, mepc = 0x80, mcause = 11.
REQ-037 Set MIE = 1 and MEIE = 1, assert ext_irq together with illegal at epc 0x40 -> mcause = 0x8000000B, excp_pcen = 0, MIE = 0, MPIE = 1.
REQ-038 After REQ-037, mret -> next cycle pcen = 1, int_ctrl_epc = 0x40, MIE = 1.
REQ-039 With MIE = 0 and timer_irq = 1, accept 5 instructions -> no pcen.
REQ-040 Trap in IDLE followed by a second ecall in the TRAP cycle -> exactly one pcen pulse, and mcause is unchanged.
REQ-041 Drop rst_n while in TRAP -> outputs go to 0 asynchronously and all CSRs read 0.
